// File: rtl/trace_calc_pkg.sv
// -----------------------------------------------------------------------------
// trace_calc_pkg
// Shared constants and types for the complex trace calculator.
//   - state_t       : controller states (IDLE / CALC / DONE)
//   - NUM_ELEM      : matrix element count (4x2 row-major = 8)
//   - ADDR_W        : element address width
//   - N_DEF, Q_DEF, ACC_WIDTH_DEF : default datapath widths
// -----------------------------------------------------------------------------
package trace_calc_pkg;

    localparam int NUM_ELEM      = 8;
    localparam int ADDR_W        = 3;

    localparam int N_DEF         = 16;
    localparam int Q_DEF         = 8;
    localparam int ACC_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage : trace_calc_pkg

// File: rtl/trace_calculator_core_cmul_conj.sv
// -----------------------------------------------------------------------------
// cmul_conj
// Combinational conj(a) * b for Q-format complex samples.
//   a_r, a_i   in  N          : first operand (conjugated)
//   b_r, b_i   in  N          : second operand
//   term_r     out ACC_WIDTH  : (a_r*b_r + a_i*b_i) >>> Q, sign-extended
//   term_i     out ACC_WIDTH  : (a_r*b_i - a_i*b_r) >>> Q, sign-extended
// -----------------------------------------------------------------------------
module cmul_conj #(
    parameter int N         = trace_calc_pkg::N_DEF,
    parameter int Q         = trace_calc_pkg::Q_DEF,
    parameter int ACC_WIDTH = trace_calc_pkg::ACC_WIDTH_DEF
) (
    input  logic signed [N-1:0]         a_r,
    input  logic signed [N-1:0]         a_i,
    input  logic signed [N-1:0]         b_r,
    input  logic signed [N-1:0]         b_i,
    output logic signed [ACC_WIDTH-1:0] term_r,
    output logic signed [ACC_WIDTH-1:0] term_i
);

    // Cross-sums need 2N+1 bits; work in whichever is wider of that and the
    // accumulator so the shift never loses sign information.
    localparam int SUM_W = 2 * N + 1;
    localparam int EXT_W = (SUM_W > ACC_WIDTH) ? SUM_W : ACC_WIDTH;

    logic signed [2*N-1:0]  p_rr;
    logic signed [2*N-1:0]  p_ii;
    logic signed [2*N-1:0]  p_ri;
    logic signed [2*N-1:0]  p_ir;
    logic signed [EXT_W-1:0] sum_r;
    logic signed [EXT_W-1:0] sum_i;

    always_comb begin
        p_rr   = a_r * b_r;
        p_ii   = a_i * b_i;
        p_ri   = a_r * b_i;
        p_ir   = a_i * b_r;
        sum_r  = EXT_W'(p_rr) + EXT_W'(p_ii);
        sum_i  = EXT_W'(p_ri) - EXT_W'(p_ir);
        // Arithmetic shift gives floor rounding for negative values.
        term_r = ACC_WIDTH'(sum_r >>> Q);
        term_i = ACC_WIDTH'(sum_i >>> Q);
    end

endmodule : cmul_conj

// File: rtl/trace_calculator_core.sv
// -----------------------------------------------------------------------------
// trace_calculator_core
// Computes tr(Y^H * G) = sum_k conj(Y[k]) * G[k] over 8 complex elements read
// one per cycle from external combinational-read RAMs.
//   clk, rst                       : clock, async active-high reset
//   start_calc      in  1          : start request (sampled in IDLE)
//   y_rd_addr       out ADDR_W     : Y RAM read address
//   y_rd_data_r/i   in  N          : Y[y_rd_addr], same-cycle data
//   g_rd_addr       out ADDR_W     : G RAM read address (== y_rd_addr)
//   g_rd_data_r/i   in  N          : G[g_rd_addr], same-cycle data
//   done_calc       out 1          : one-cycle result-valid pulse
//   trace_result_r/i out ACC_WIDTH : Q-format trace, held until next result
// -----------------------------------------------------------------------------
module trace_calculator_core
    import trace_calc_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int Q         = Q_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_calc,
    output logic [ADDR_W-1:0]           y_rd_addr,
    input  logic signed [N-1:0]         y_rd_data_r,
    input  logic signed [N-1:0]         y_rd_data_i,
    output logic [ADDR_W-1:0]           g_rd_addr,
    input  logic signed [N-1:0]         g_rd_data_r,
    input  logic signed [N-1:0]         g_rd_data_i,
    output logic                        done_calc,
    output logic signed [ACC_WIDTH-1:0] trace_result_r,
    output logic signed [ACC_WIDTH-1:0] trace_result_i
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ELEM - 1);

    state_t                      state;
    state_t                      next_state;
    logic [ADDR_W-1:0]           addr;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [ACC_WIDTH-1:0] term_r;
    logic signed [ACC_WIDTH-1:0] term_i;

    assign y_rd_addr = addr;
    assign g_rd_addr = addr;

    cmul_conj #(
        .N         (N),
        .Q         (Q),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_cmul_conj (
        .a_r    (y_rd_data_r),
        .a_i    (y_rd_data_i),
        .b_r    (g_rd_data_r),
        .b_i    (g_rd_data_i),
        .term_r (term_r),
        .term_i (term_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_calc) next_state = CALC;
            CALC:    if (addr == LAST_ADDR) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr           <= '0;
            acc_r          <= '0;
            acc_i          <= '0;
            done_calc      <= 1'b0;
            trace_result_r <= '0;
            trace_result_i <= '0;
        end else begin
            done_calc <= 1'b0;
            case (state)
                IDLE: begin
                    addr <= '0;
                    if (start_calc) begin
                        acc_r <= '0;
                        acc_i <= '0;
                    end
                end
                CALC: begin
                    acc_r <= acc_r + term_r;
                    acc_i <= acc_i + term_i;
                    addr  <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
                end
                DONE: begin
                    // Result and pulse are registered on the edge leaving
                    // DONE, so they appear together 9 edges after start.
                    trace_result_r <= acc_r;
                    trace_result_i <= acc_i;
                    done_calc      <= 1'b1;
                    addr           <= '0;
                end
                default: addr <= '0;
            endcase
        end
    end

endmodule : trace_calculator_core

// File: tb/tb_trace_calculator_core.sv
module tb_trace_calculator_core;

    logic               clk;
    logic               rst;
    logic               start_calc;
    logic [2:0]         y_rd_addr;
    logic [2:0]         g_rd_addr;
    logic signed [15:0] y_rd_data_r;
    logic signed [15:0] y_rd_data_i;
    logic signed [15:0] g_rd_data_r;
    logic signed [15:0] g_rd_data_i;
    logic               done_calc;
    logic signed [31:0] trace_result_r;
    logic signed [31:0] trace_result_i;

    logic signed [15:0] y_mem_r [8];
    logic signed [15:0] y_mem_i [8];
    logic signed [15:0] g_mem_r [8];
    logic signed [15:0] g_mem_i [8];

    logic [63:0] sb_q [$];
    int checks = 0;
    int errors = 0;

    trace_calculator_core #(
        .N         (16),
        .ACC_WIDTH (32),
        .Q         (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_calc     (start_calc),
        .y_rd_addr      (y_rd_addr),
        .y_rd_data_r    (y_rd_data_r),
        .y_rd_data_i    (y_rd_data_i),
        .g_rd_addr      (g_rd_addr),
        .g_rd_data_r    (g_rd_data_r),
        .g_rd_data_i    (g_rd_data_i),
        .done_calc      (done_calc),
        .trace_result_r (trace_result_r),
        .trace_result_i (trace_result_i)
    );

    assign y_rd_data_r = y_mem_r[y_rd_addr];
    assign y_rd_data_i = y_mem_i[y_rd_addr];
    assign g_rd_data_r = g_mem_r[g_rd_addr];
    assign g_rd_data_i = g_mem_i[g_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference trace: independent floor-shift model in 64-bit arithmetic.
    function automatic logic [63:0] model_trace();
        longint ar = 0;
        longint ai = 0;
        for (int k = 0; k < 8; k++) begin
            longint yr = y_mem_r[k];
            longint yi = y_mem_i[k];
            longint gr = g_mem_r[k];
            longint gi = g_mem_i[k];
            ar += (yr * gr + yi * gi) >>> 8;
            ai += (yr * gi - yi * gr) >>> 8;
        end
        return {ar[31:0], ai[31:0]};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done_calc) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed=done expected=no_done");
            end
            if (sb_q.size() != 0) begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("sb_real", trace_result_r, e[63:32]);
                chk("sb_imag", trace_result_i, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_main();
        int yr [8] = '{1, 2, 3, 1, 1, 1, 1, 1};
        int yi [8] = '{1, 2, 3, 1, 1, 2, 3, 4};
        int gr [8] = '{1, 2, 2, 2, 5, 6, 7, 8};
        int gi [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        for (int k = 0; k < 8; k++) begin
            y_mem_r[k] = 16'(yr[k] * 256);
            y_mem_i[k] = 16'(yi[k] * 256);
            g_mem_r[k] = 16'(gr[k] * 256);
            g_mem_i[k] = 16'(gi[k] * 256);
        end
    endtask

    task automatic load_const(input logic signed [15:0] yr, input logic signed [15:0] yi,
                              input logic signed [15:0] gr, input logic signed [15:0] gi);
        for (int k = 0; k < 8; k++) begin
            y_mem_r[k] = yr;
            y_mem_i[k] = yi;
            g_mem_r[k] = gr;
            g_mem_i[k] = gi;
        end
    endtask

    // One full calculation with address and latency checks; the scoreboard
    // consumer verifies the result values at the done pulse.
    task automatic run_calc(input string tag);
        sb_q.push_back(model_trace());
        start_calc = 1'b1;
        tick();
        start_calc = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) begin
                chk({tag, "_y_addr"}, 32'(y_rd_addr), 32'(k));
                chk({tag, "_g_addr"}, 32'(g_rd_addr), 32'(k));
            end
            chk({tag, "_done"}, 32'(done_calc), (k == 9) ? 32'd1 : 32'd0);
            if (k < 10) tick();
        end
    endtask

    initial begin
        logic [31:0] held_r;
        logic [31:0] held_i;
        rst        = 1'b1;
        start_calc = 1'b0;
        load_main();
        #2;
        chk("rst_real", trace_result_r, 32'h0);
        chk("rst_imag", trace_result_i, 32'h0);
        chk("rst_done", 32'(done_calc), 32'h0);
        chk("rst_addr", 32'(y_rd_addr), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_addr", 32'(y_rd_addr), 32'h0);

        // Main vector
        run_calc("main");
        chk("main_real", trace_result_r, 32'h0000_5700);
        chk("main_imag", trace_result_i, 32'hFFFF_C900);

        // Identity: Y = G = 1+0j
        load_const(16'sd256, 16'sd0, 16'sd256, 16'sd0);
        run_calc("ident");
        chk("ident_real", trace_result_r, 32'h0000_0800);
        chk("ident_imag", trace_result_i, 32'h0);

        // Reset mid-CALC at addr=4
        load_main();
        start_calc = 1'b1;
        tick();
        start_calc = 1'b0;
        repeat (4) tick();
        chk("pre_rst_addr", 32'(y_rd_addr), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_real", trace_result_r, 32'h0);
        chk("midrst_imag", trace_result_i, 32'h0);
        chk("midrst_addr", 32'(y_rd_addr), 32'h0);
        chk("midrst_done", 32'(done_calc), 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("midrst_no_done", 32'(done_calc), 32'h0);
            tick();
        end
        run_calc("restart");
        chk("restart_real", trace_result_r, 32'h0000_5700);
        chk("restart_imag", trace_result_i, 32'hFFFF_C900);

        // start_calc held high: one done per 10-cycle loop
        repeat (3) sb_q.push_back(model_trace());
        start_calc = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 29) start_calc = 1'b0;
            chk("held_done", 32'(done_calc), (k % 10 == 9) ? 32'd1 : 32'd0);
        end
        chk("held_real", trace_result_r, 32'h0000_5700);
        chk("held_imag", trace_result_i, 32'hFFFF_C900);

        // Sign/floor: Y = 0+1j, G = 1/256 real
        load_const(16'sd0, 16'sd256, 16'sd1, 16'sd0);
        run_calc("floor");
        chk("floor_real", trace_result_r, 32'h0);
        chk("floor_imag", trace_result_i, 32'hFFFF_FFF8);

        // Result hold: change RAM without start
        held_r = trace_result_r;
        held_i = trace_result_i;
        load_main();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold_real", trace_result_r, held_r);
            chk("hold_imag", trace_result_i, held_i);
            chk("hold_done", 32'(done_calc), 32'h0);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trace_calculator_core

// File: doc/trace_calculator_core.md
Name: trace_calculator_core

Overview:
- Computes the complex trace tr(Y^H·G) of two 4x2 complex fixed-point matrices, both stored row-major as 8 elements.
- The result equals the sum over k=0..7 of conj(Y[k])·G[k].
- Reads both matrices through external combinational-read RAM ports, one element per cycle.
- Sits after the Y/G buffers in the detection datapath and returns a Q-format complex scalar with a done pulse.

Parameters:
- N, 16, width of each real/imag input sample (signed, Q fractional bits).
- ACC_WIDTH, 32, width of accumulator and result outputs (signed).
- Q, 8, number of fractional bits in inputs and result.
- NUM_ELEM, 8, matrix element count; fixed at 8 in this revision. The address width is 3.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_calc  in  1  start request, sampled in IDLE.
- y_rd_addr  out  3  Y RAM read address.
- y_rd_data_r  in  N  Y[y_rd_addr] real part; combinational, valid the same cycle.
- y_rd_data_i  in  N  Y[y_rd_addr] imaginary part.
- g_rd_addr  out  3  G RAM read address; always equal to y_rd_addr.
- g_rd_data_r  in  N  G[g_rd_addr] real part; combinational.
- g_rd_data_i  in  N  G[g_rd_addr] imaginary part.
- done_calc  out  1  one-cycle pulse: result valid.
- trace_result_r  out  ACC_WIDTH  trace real part, Q format.
- trace_result_i  out  ACC_WIDTH  trace imaginary part, Q format.

Behaviour:
- Reset (async, active-high): state=IDLE, addr=0, acc_r/acc_i=0, done_calc=0, trace_result_r/i=0.
- State machine: IDLE, CALC, DONE.
- IDLE:
  - addr held at 0.
  - On a rising edge with start_calc=1: clear both accumulators, addr=0, go to CALC.
- CALC (exactly 8 cycles, addr 0..7):
  - Each cycle, add to the accumulators the term for the current addr:
    - real term: yr·gr + yi·gi
    - imag term: yr·gi − yi·gr
  - Products are 2N-bit signed. Each cross-sum is 2N+1 bits.
  - Each cross-sum is arithmetic-shifted right by Q (floor), sign-extended to ACC_WIDTH, then added.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
  - addr increments each cycle. After accumulating addr=7, go to DONE and return addr to 0.
- DONE (1 cycle):
  - trace_result_r/i are registered from the accumulators.
  - done_calc=1 for this cycle only.
  - Next state is IDLE.
- Results hold their value until the next DONE or reset.
- Latency: done_calc rises 9 cycles after the edge that samples start_calc.
- start_calc is ignored in CALC and DONE. If it is still high in IDLE, a new calculation begins.
- Reset mid-CALC aborts the calculation; no done pulse is produced.
- Read addresses are registered state. The data inputs are used combinationally in the same cycle.

Decomposition:
- Package trace_calc_pkg holds:
  - the state enum (IDLE/CALC/DONE)
  - NUM_ELEM=8 and ADDR_W=3
  - default N, Q and ACC_WIDTH constants
- One sub-module, cmul_conj:
  - combinational conj(a)·b with Q-shift
  - outputs the two sign-extended ACC_WIDTH terms
- The top module holds the FSM, address counter, accumulators and output registers.

Test Plan:
- Main vector. Q8 inputs:
  - Y = {1+1j, 2+2j, 3+3j, 1+1j, 1+1j, 1+2j, 1+3j, 1+4j}
  - G = {1+1j, 2+2j, 2+3j, 2+4j, 5+1j, 6+2j, 7+3j, 8+4j}
  - Pulse start_calc -> done_calc pulses once, 9 cycles after start.
  - trace_result_r = 0x00005700 (87.0) and trace_result_i = 0xFFFFC900 (−55.0).
  - Addresses step 0..7 in CALC.
- Identity check: Y = G = all 1+0j -> real 0x00000800 (8.0), imag 0.
- Reset behaviour:
  - Assert rst mid-CALC (addr=4) -> outputs 0, no done pulse.
  - Then restart with the main vector -> same results as the main vector.
- Start while busy: start_calc held high through CALC -> one done per 10-cycle loop (IDLE→CALC×8→DONE). Results are identical each loop.
- Sign and rounding:
  - All Y = 0+1j, all G = 0x0001 (1/256) real.
  - Each imag term = −1 LSB·1 >>8 = −1 (floor).
  - Result: imag = −8 (0xFFFFFFF8), real 0.
- Result hold: after done, change RAM contents without start -> trace_result_r/i unchanged.
